frame_assembler: RTL and testbench
==================================

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 Parameter FRAME_LEN SHALL default to 256 and set the number of samples per frame.
REQ-002 Parameter SAMPLE_W SHALL default to 8 and set the sample width in bits.
REQ-003 The block SHALL use one clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the sole clock.
REQ-005 Port rst SHALL be an input, 1 bit wide, and act as a synchronous active-high reset.
REQ-006 Port in_data SHALL be an input, SAMPLE_W bits wide, and carry one streaming unsigned sample.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, and indicate that in_data holds a valid sample.
REQ-008 Port in_ready SHALL be an output, 1 bit wide, and indicate that the block can accept a sample.
REQ-009 Port flush SHALL be an input, 1 bit wide, and request zero-padding and emission of the current partial frame.
REQ-010 Port frame_out SHALL be an output array [0:FRAME_LEN-1] of SAMPLE_W-bit samples holding the assembled frame, in the same layout the FIR stage consumes.
REQ-011 Port frame_valid SHALL be an output, 1 bit wide, and indicate that frame_out holds an unconsumed frame.
REQ-012 Port frame_ready SHALL be an input, 1 bit wide, and indicate that the downstream stage accepts frame_out.
REQ-013 Port frame_count SHALL be an output, 16 bits wide, counting emitted frames and wrapping modulo 2^16.

Function
REQ-014 A sample SHALL be accepted on each clk edge where in_valid and in_ready are both 1, and written to fill-bank position wr_idx.
REQ-015 wr_idx SHALL increment by 1 per accepted sample and run 0..FRAME_LEN-1.
REQ-016 The fill bank and the output bank (frame_out) SHALL be separate registers, so filling continues while a frame is held.
REQ-017 The output slot is free in a cycle when frame_valid==0, or when frame_valid==1 and frame_ready==1 in that cycle.
REQ-018 The fill FSM SHALL have two states, FILL and STALL, and in_ready SHALL equal (state==FILL && !rst).
REQ-019 In FILL, on acceptance of the sample at wr_idx==FRAME_LEN-1 with the output slot free, the block SHALL load frame_out with the complete frame (including that sample), set frame_valid=1, wrap wr_idx to 0 and stay in FILL.
REQ-020 In FILL, on acceptance of the last sample with the output slot not free, the FSM SHALL enter STALL and hold the complete fill bank.
REQ-021 In STALL, on the first edge where frame_valid&&frame_ready, frame_out SHALL load the held bank, frame_valid SHALL stay 1, wr_idx SHALL become 0 and the FSM SHALL return to FILL.
REQ-022 frame_valid SHALL be asserted in the cycle immediately after the edge that completes the frame (latency 1 cycle from the last accepted sample).
REQ-023 frame_valid SHALL clear on an edge with frame_ready==1 unless a new frame loads on the same edge.
REQ-024 frame_out SHALL remain stable while frame_valid==1 and frame_ready==0.
REQ-025 flush in FILL with wr_idx>0 SHALL behave as a frame completion: positions >= the post-acceptance wr_idx SHALL be zero-filled, and REQ-019/020 SHALL then apply.
REQ-026 flush together with an accepted sample SHALL store the sample first, then pad the remaining positions.
REQ-027 flush with wr_idx==0 and no sample accepted, or flush in STALL, SHALL be ignored.
REQ-028 frame_count SHALL increment by 1 on every edge that loads frame_out.

Reset
REQ-029 When rst==1 at an edge, state SHALL become FILL, wr_idx=0, all frame_out entries=0, frame_valid=0, frame_count=0, and fill-bank contents SHALL be cleared to 0.
REQ-030 Reset mid-frame or in STALL SHALL discard all partial and held data; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Package frame_pkg SHALL hold FRAME_LEN, SAMPLE_W, sample_t, frame_t (unpacked array of sample_t) and the FSM enum fill_state_t, shared with the FIR stage.
REQ-032 The FSM and wr_idx counter SHALL be in one sub-module, frame_fill_ctrl; the bank registers SHALL stay in frame_assembler.

Verification
REQ-033 Stream 256 samples of value i%256 back-to-back with frame_ready=1 -> frame_valid=1 one cycle after the 256th sample, frame_out[k]==k, frame_count==1.
REQ-034 Hold frame_ready=0 and stream 512 samples -> in_ready=0 after sample 512 (STALL); raise frame_ready -> second frame loads next edge, frame_valid stays 1, in_ready=1, frame_count==2.
REQ-035 Send 10 samples of 0xAA, then pulse flush -> frame_out[0..9]==0xAA, frame_out[10..255]==0, frame_valid=1 next cycle.
REQ-036 Send 9 samples, then the 10th with flush in the same cycle -> frame_out[0..9] equal the samples, frame_out[10..255]==0.
REQ-037 Assert rst for 1 cycle while in STALL with frame_valid=1 -> all outputs 0, in_ready=1 the next cycle, and a new 256-sample stream yields a frame with frame_count==1.
REQ-038 Pulse flush with wr_idx==0 -> no frame_valid and frame_count unchanged.

Source files
------------

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame assembler and the FIR stage that consumes
// its frames. The frame layout is an unpacked array indexed 0..FRAME_LEN-1,
// where index 0 is the first sample received.
//
// Contents:
//   FRAME_LEN    - samples per frame
//   SAMPLE_W     - sample width in bits
//   sample_t     - one unsigned sample
//   frame_t      - one complete frame (unpacked array of sample_t)
//   fill_state_t - fill FSM states (FILL, STALL)
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam int FRAME_LEN = 256;
    localparam int SAMPLE_W  = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t frame_t [0:FRAME_LEN-1];

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/frame_fill_ctrl.sv
// -----------------------------------------------------------------------------
// frame_fill_ctrl
// Fill FSM and write-index counter for frame_assembler. Decides when a sample
// is accepted, when a frame is complete (last sample or flush), and whether the
// finished frame goes straight to the output bank or has to wait in STALL.
//
// Handshake: a sample transfers on a clk edge where in_valid && in_ready; a
// frame transfers on a clk edge where frame_valid && frame_ready. Neither
// valid may depend on its own ready.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - upstream sample valid
//   flush        - request to pad and emit the current partial frame
//   frame_valid  - output bank currently holds an unconsumed frame
//   frame_ready  - downstream accepts the output bank this cycle
//   in_ready     - block can accept a sample (FILL and not in reset)
//   accept       - sample accepted this cycle
//   complete     - fill bank is finishing a frame this cycle (in FILL)
//   load_direct  - the frame being completed this cycle loads frame_out
//   load_held    - the frame held during STALL loads frame_out
//   wr_idx       - fill-bank write position
//   pad_from     - first position to zero-fill when completing (post-accept index)
//   state        - current FSM state, exposed for debug/checkers
// -----------------------------------------------------------------------------
module frame_fill_ctrl
    import frame_pkg::*;
#(
    parameter int  FRAME_LEN = frame_pkg::FRAME_LEN,
    localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             frame_valid,
    input  logic             frame_ready,
    output logic             in_ready,
    output logic             accept,
    output logic             complete,
    output logic             load_direct,
    output logic             load_held,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W:0]   pad_from,
    output fill_state_t      state
);

    fill_state_t      state_next;
    logic [IDX_W-1:0] idx_next;
    logic             slot_free;
    logic             last;

    assign in_ready  = (state == FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign slot_free = !frame_valid || frame_ready;
    assign last      = accept && (wr_idx == IDX_W'(FRAME_LEN - 1));
    // Index one past the newest stored sample; equals FRAME_LEN on the last
    // sample, so nothing gets padded for a naturally full frame.
    assign pad_from  = {1'b0, wr_idx} + (IDX_W + 1)'(accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            wr_idx <= '0;
        end else begin
            state  <= state_next;
            wr_idx <= idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = wr_idx;
        complete    = 1'b0;
        load_direct = 1'b0;
        load_held   = 1'b0;
        case (state)
            FILL: begin
                // flush with an empty bank and no sample this cycle is ignored
                if (last || (flush && ((wr_idx != '0) || accept))) begin
                    complete = 1'b1;
                    idx_next = '0;
                    if (slot_free) begin
                        load_direct = 1'b1;
                    end else begin
                        state_next = STALL;
                    end
                end else if (accept) begin
                    idx_next = wr_idx + 1'b1;
                end
            end
            STALL: begin
                if (frame_valid && frame_ready) begin
                    load_held  = 1'b1;
                    idx_next   = '0;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/frame_assembler.sv
// -----------------------------------------------------------------------------
// frame_assembler
// Collects a stream of samples into FRAME_LEN-sample frames for the FIR stage.
// A fill bank collects samples while a separate output bank (frame_out) holds
// the last emitted frame, so filling continues while downstream is busy. A
// second complete frame waits in the fill bank (STALL) until the output slot
// frees up. flush zero-pads and emits a partial frame.
//
// Handshake: a sample transfers on a clk edge where in_valid && in_ready; a
// frame transfers on a clk edge where frame_valid && frame_ready. Neither
// valid may depend on its own ready.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_data      - streaming unsigned sample
//   in_valid     - in_data holds a valid sample
//   in_ready     - block can accept a sample
//   flush        - pad and emit the current partial frame
//   frame_out    - assembled frame, index 0 is the earliest sample
//   frame_valid  - frame_out holds an unconsumed frame
//   frame_ready  - downstream accepts frame_out
//   frame_count  - number of frames loaded into frame_out, modulo 2^16
// -----------------------------------------------------------------------------
module frame_assembler
    import frame_pkg::*;
#(
    parameter int FRAME_LEN = frame_pkg::FRAME_LEN,
    parameter int SAMPLE_W  = frame_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [SAMPLE_W-1:0] frame_out [0:FRAME_LEN-1],
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [15:0]         frame_count
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [SAMPLE_W-1:0] fill_bank [0:FRAME_LEN-1];
    logic [SAMPLE_W-1:0] bank_next [0:FRAME_LEN-1];

    logic             accept;
    logic             complete;
    logic             load_direct;
    logic             load_held;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W:0]   pad_from;
    fill_state_t      fill_state;

    frame_fill_ctrl #(
        .FRAME_LEN (FRAME_LEN)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .in_ready    (in_ready),
        .accept      (accept),
        .complete    (complete),
        .load_direct (load_direct),
        .load_held   (load_held),
        .wr_idx      (wr_idx),
        .pad_from    (pad_from),
        .state       (fill_state)
    );

    // Fill bank as it will look after this edge: the accepted sample is
    // stored first, then on completion every position from pad_from up is
    // zeroed. A direct load copies this view so the output includes the
    // sample accepted on the completing edge.
    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            bank_next[i] = fill_bank[i];
            if (accept && (wr_idx == IDX_W'(i))) begin
                bank_next[i] = in_data;
            end
            if (complete && ((IDX_W + 1)'(i) >= pad_from)) begin
                bank_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank   <= '{default: '0};
            frame_out   <= '{default: '0};
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            // Bank is frozen in STALL so the held frame survives until loaded.
            if ((fill_state == FILL) && (accept || complete)) begin
                fill_bank <= bank_next;
            end

            if (load_direct) begin
                frame_out <= bank_next;
            end else if (load_held) begin
                frame_out <= fill_bank;
            end

            if (load_direct || load_held) begin
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// -----------------------------------------------------------------------------
// tb_frame_assembler
// Self-checking bench for frame_assembler. A frame-level reference model
// (queue of pending samples, held frame, output frame, frame counter) is
// advanced once per clock edge with the same inputs the DUT sees; outputs are
// compared 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_frame_assembler;

  localparam int FL = 256;
  localparam int SW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [SW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [SW-1:0] frame_out [0:FL-1];
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [15:0]   frame_count;

  frame_assembler #(
    .FRAME_LEN (FL),
    .SAMPLE_W  (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_count (frame_count)
  );

  // scoreboard / reference model
  logic [SW-1:0] exp_q[$];             // samples of the frame being collected
  logic [SW-1:0] m_out  [0:FL-1];
  logic [SW-1:0] m_held [0:FL-1];
  bit            m_valid;
  bit            m_stalled;
  bit            m_loaded;
  logic [15:0]   m_count;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sig(input logic [SW-1:0] a [0:FL-1]);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < FL; k++) s = s + 32'(k + 1) * 32'(a[k]);
    return s;
  endfunction

  task automatic model_step(input logic v, input logic [SW-1:0] d, input logic f,
                            input logic fr, input logic r);
    logic [SW-1:0] frm [0:FL-1];
    bit slot_free;
    m_loaded = 1'b0;
    if (r) begin
      exp_q.delete();
      m_valid   = 1'b0;
      m_stalled = 1'b0;
      m_count   = 16'd0;
      for (int k = 0; k < FL; k++) m_out[k] = '0;
    end else if (m_stalled) begin
      if (fr) begin
        m_out     = m_held;
        m_valid   = 1'b1;
        m_loaded  = 1'b1;
        m_count   = m_count + 16'd1;
        m_stalled = 1'b0;
      end
    end else begin
      slot_free = !m_valid || fr;
      if (v) exp_q.push_back(d);
      if (exp_q.size() == FL || (f && exp_q.size() > 0)) begin
        for (int k = 0; k < FL; k++) frm[k] = (k < exp_q.size()) ? exp_q[k] : '0;
        exp_q.delete();
        if (slot_free) begin
          m_out    = frm;
          m_valid  = 1'b1;
          m_loaded = 1'b1;
          m_count  = m_count + 16'd1;
        end else begin
          m_held    = frm;
          m_stalled = 1'b1;
        end
      end else if (fr) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance model, compare
  task automatic cycle(input logic v, input logic [SW-1:0] d, input logic f,
                       input logic fr, input logic r);
    in_valid    = v;
    in_data     = d;
    flush       = f;
    frame_ready = fr;
    rst         = r;
    @(posedge clk);
    model_step(v, d, f, fr, r);
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_stalled && !r));
    check("frame_valid", 32'(frame_valid), 32'(m_valid));
    check("frame_count", 32'(frame_count), 32'(m_count));
    check("frame_sig", sig(frame_out), sig(m_out));
    if (m_loaded) begin
      for (int k = 0; k < FL; k++)
        check($sformatf("frame_out[%0d]", k), 32'(frame_out[k]), 32'(m_out[k]));
    end
  endtask

  initial begin
    logic [SW-1:0] smp [0:9];
    logic [15:0]   c0;

    for (int k = 0; k < FL; k++) begin
      m_out[k]  = '0;
      m_held[k] = '0;
    end
    m_valid = 1'b0; m_stalled = 1'b0; m_loaded = 1'b0; m_count = 16'd0;

    // reset state
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("rst_frame_out0", 32'(frame_out[0]), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // full frame, back-to-back, downstream always ready
    for (int i = 0; i < FL; i++) cycle(1, SW'(i % 256), 0, 1, 0);
    check("seq_valid", 32'(frame_valid), 32'd1);
    check("seq_count", 32'(frame_count), 32'd1);
    for (int k = 0; k < FL; k++)
      check($sformatf("seq_out[%0d]", k), 32'(frame_out[k]), 32'(k));

    // downstream stalled: two frames, second one held in STALL
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 2 * FL; i++) cycle(1, SW'($urandom_range(0, 255)), 0, 0, 0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_count", 32'(frame_count), 32'd2);
    cycle(0, 0, 0, 1, 0);
    check("release_valid", 32'(frame_valid), 32'd1);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_count", 32'(frame_count), 32'd3);

    // flush after 10 samples of 0xAA
    for (int i = 0; i < 10; i++) cycle(1, 8'hAA, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    check("flush_valid", 32'(frame_valid), 32'd1);
    for (int k = 0; k < FL; k++)
      check($sformatf("flush_out[%0d]", k), 32'(frame_out[k]), (k < 10) ? 32'hAA : 32'd0);

    // flush together with the 10th sample
    for (int i = 0; i < 10; i++) smp[i] = SW'($urandom_range(1, 255));
    for (int i = 0; i < 9; i++) cycle(1, smp[i], 0, 1, 0);
    cycle(1, smp[9], 1, 1, 0);
    check("flush_same_valid", 32'(frame_valid), 32'd1);
    for (int k = 0; k < FL; k++)
      check($sformatf("flush_same_out[%0d]", k), 32'(frame_out[k]),
            (k < 10) ? 32'(smp[k]) : 32'd0);

    // flush with an empty fill bank is ignored
    cycle(0, 0, 0, 1, 0);
    c0 = frame_count;
    cycle(0, 0, 1, 1, 0);
    check("empty_flush_valid", 32'(frame_valid), 32'd0);
    check("empty_flush_count", 32'(frame_count), 32'(c0));

    // reset while in STALL with a frame valid
    for (int i = 0; i < 2 * FL; i++) cycle(1, SW'($urandom_range(0, 255)), 0, 0, 0);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("stall_rst_valid", 32'(frame_valid), 32'd0);
    check("stall_rst_count", 32'(frame_count), 32'd0);
    for (int k = 0; k < FL; k++)
      check($sformatf("stall_rst_out[%0d]", k), 32'(frame_out[k]), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < FL; i++) cycle(1, SW'($urandom_range(0, 255)), 0, 1, 0);
    check("post_rst_count", 32'(frame_count), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) < 70), SW'($urandom_range(0, 255)),
            logic'($urandom_range(0, 99) < 3), logic'($urandom_range(0, 99) < 50),
            logic'($urandom_range(0, 999) < 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
